// File: rtl/vx_ifetch_stage_pkg.sv
// Shared fetch-stage types: per-warp metadata held while a fetch is in flight,
// and the decode-bound response record.
package vx_ifetch_stage_pkg;

    localparam int IF_NUM_WARPS     = 4;
    localparam int IF_NUM_THREADS   = 4;
    localparam int IF_NW_BITS       = (IF_NUM_WARPS > 1) ? $clog2(IF_NUM_WARPS) : 1;
    localparam int ICACHE_TAG_WIDTH = IF_NW_BITS;

    typedef struct packed {
        logic [IF_NUM_THREADS-1:0] tmask;
        logic [31:0]               PC;
    } ifetch_meta_t;

    typedef struct packed {
        logic [IF_NW_BITS-1:0]     wid;
        logic [IF_NUM_THREADS-1:0] tmask;
        logic [31:0]               PC;
        logic [31:0]               instr;
    } ifetch_rsp_t;

endpackage

// File: rtl/vx_skid_buffer2.sv
// Two-entry elastic FIFO; in_ready decodes registered occupancy only, so there
// is no combinational path from out_ready back to the producer.
module vx_skid_buffer2 #(
    parameter int DATAW = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    input  logic             out_ready
);

    logic [DATAW-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // The head slot is never the write target while occupied, so outputs hold under stall.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/vx_ifetch_stage.sv
// Instruction fetch: forwards scheduler requests to the I-cache, parks {tmask, PC}
// per warp until the (possibly out-of-order) response returns, then queues for decode.
module vx_ifetch_stage
    import vx_ifetch_stage_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ifetch_req_valid,
    input  logic [NW_BITS-1:0]     ifetch_req_wid,
    input  logic [NUM_THREADS-1:0] ifetch_req_tmask,
    input  logic [31:0]            ifetch_req_PC,
    output logic                   ifetch_req_ready,

    output logic                   icache_req_valid,
    output logic [29:0]            icache_req_addr,
    output logic [NW_BITS-1:0]     icache_req_tag,
    input  logic                   icache_req_ready,

    input  logic                   icache_rsp_valid,
    input  logic [31:0]            icache_rsp_data,
    input  logic [NW_BITS-1:0]     icache_rsp_tag,
    output logic                   icache_rsp_ready,

    output logic                   ifetch_rsp_valid,
    output logic [NW_BITS-1:0]     ifetch_rsp_wid,
    output logic [NUM_THREADS-1:0] ifetch_rsp_tmask,
    output logic [31:0]            ifetch_rsp_PC,
    output logic [31:0]            ifetch_rsp_instr,
    input  logic                   ifetch_rsp_ready,

    output logic                   busy
);

    // The shared record types are sized from the package; refuse mismatched builds.
    if (NUM_THREADS != IF_NUM_THREADS || NW_BITS != ICACHE_TAG_WIDTH) begin : g_cfg_err
        $error("vx_ifetch_stage: parameters do not match vx_ifetch_stage_pkg widths");
    end

    logic [NUM_WARPS-1:0] pending;
    ifetch_meta_t         meta [NUM_WARPS];
    ifetch_meta_t         rsp_meta;
    ifetch_rsp_t          push_data;
    ifetch_rsp_t          head;
    logic                 blk;
    logic                 req_fire;
    logic                 rsp_fire;

    // A warp has at most one fetch outstanding; the wid doubles as the I-cache tag.
    assign blk              = pending[ifetch_req_wid];
    assign icache_req_valid = ifetch_req_valid & ~blk;
    assign ifetch_req_ready = icache_req_ready & ~blk;
    assign icache_req_addr  = ifetch_req_PC[31:2];
    assign icache_req_tag   = ifetch_req_wid;

    assign req_fire = ifetch_req_valid & ifetch_req_ready;
    assign rsp_fire = icache_rsp_valid & icache_rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (rsp_fire) pending[icache_rsp_tag] <= 1'b0;
            if (req_fire) pending[ifetch_req_wid] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) meta[ifetch_req_wid] <= '{tmask: ifetch_req_tmask, PC: ifetch_req_PC};
    end

    assign rsp_meta  = meta[icache_rsp_tag];
    assign push_data = '{wid:   icache_rsp_tag,
                         tmask: rsp_meta.tmask,
                         PC:    rsp_meta.PC,
                         instr: icache_rsp_data};

    vx_skid_buffer2 #(
        .DATAW ($bits(ifetch_rsp_t))
    ) out_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (icache_rsp_valid),
        .in_data   (push_data),
        .in_ready  (icache_rsp_ready),
        .out_valid (ifetch_rsp_valid),
        .out_data  (head),
        .out_ready (ifetch_rsp_ready)
    );

    assign ifetch_rsp_wid   = head.wid;
    assign ifetch_rsp_tmask = head.tmask;
    assign ifetch_rsp_PC    = head.PC;
    assign ifetch_rsp_instr = head.instr;

    assign busy = (|pending) | ifetch_rsp_valid;

    always @(posedge clk) begin
        if (!reset) begin
            if (rsp_fire)
                assert (pending[icache_rsp_tag])
                else $error("core%0d ifetch: response for non-pending wid %0d", CORE_ID, icache_rsp_tag);
            if (req_fire)
                assert (ifetch_req_PC[1:0] == 2'b00)
                else $error("core%0d ifetch: unaligned PC %h", CORE_ID, ifetch_req_PC);
        end
    end

endmodule
